// File: rtl/point_referee.sv
`default_nettype none
// ============================================================================
// Module      : point_referee
// Description : Pong-style point referee. It handles serve timing, goal
//               detection, scoring and the win/game-over decision.
//               Optional macro WIN_BY_TWO_EN makes a win need a two-point lead.
// Revision    : 1.0 - initial release
// ============================================================================
module point_referee #(
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int GOAL_LEFT   = 8,
  parameter int GOAL_RIGHT  = 632
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic       play_en,
  output logic       serve_pulse,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_POINT      = 3'd3,
    S_OVER       = 3'd4
  } state_t;

  localparam logic [7:0] c_serve_delay = 8'(SERVE_DELAY);
  localparam logic [4:0] c_win_score   = 5'(WIN_SCORE);
  localparam logic [9:0] c_goal_left   = 10'(GOAL_LEFT);
  localparam logic [9:0] c_goal_right  = 10'(GOAL_RIGHT);

  state_t     r_state;
  logic [7:0] r_cnt;

  logic [3:0] w_scorer;
  logic [3:0] w_other;
  logic       w_lead_ok;
  logic       w_win;

  // serve_dir already points at the scorer: 1 means player1 just scored.
  always_comb begin
    w_scorer = serve_dir ? score1 : score2;
    w_other  = serve_dir ? score2 : score1;
`ifdef WIN_BY_TWO_EN
    w_lead_ok = ({1'b0, w_scorer} >= ({1'b0, w_other} + 5'd2));
`else
    w_lead_ok = 1'b1;
`endif
    w_win = (w_scorer == 4'd15) || (({1'b0, w_scorer} >= c_win_score) && w_lead_ok);
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      score1      <= 4'd0;
      score2      <= 4'd0;
      play_en     <= 1'b0;
      serve_pulse <= 1'b0;
      serve_dir   <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      serve_pulse <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            r_cnt     <= c_serve_delay;
            r_state   <= S_SERVE_WAIT;
          end
        end
        S_SERVE_WAIT: begin
          if (frame_tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              serve_pulse <= 1'b1;
              play_en     <= 1'b1;
              r_state     <= S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (ball_x <= c_goal_left) begin
              score2    <= sat_inc(score2);
              serve_dir <= 1'b0;
              play_en   <= 1'b0;
              r_state   <= S_POINT;
            end else if (ball_x >= c_goal_right) begin
              score1    <= sat_inc(score1);
              serve_dir <= 1'b1;
              play_en   <= 1'b0;
              r_state   <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (w_win) begin
            game_over <= 1'b1;
            winner    <= ~serve_dir;
            r_state   <= S_OVER;
          end else begin
            r_cnt   <= c_serve_delay;
            r_state <= S_SERVE_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
